// File: rtl/led_matrix_scan_driver.sv
// Row-multiplexed LED matrix scan driver: a shadow frame is loaded over valid/ready and
// swapped tear-free into the active frame at each frame boundary, or at once while the display is dark.
module led_matrix_scan_driver #(
  parameter int ROWS           = 7,
  parameter int COLS           = 5,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK          = 2,
  parameter int TRANSPOSE      = 1,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int COL_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_out,
  output logic                 frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam logic [ROWS-1:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};
  localparam logic [COLS-1:0] COL_OFF = (COL_ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

  logic [PW-1:0]                presc_q, presc_d;
  logic [RW-1:0]                row_q, row_d;
  logic [ROWS-1:0][COLS-1:0]    shadow_q, shadow_d;
  logic [ROWS-1:0][COLS-1:0]    active_q, active_d;
  logic                         pending_q, pending_d;
  logic [ROWS-1:0]              row_sel_q, row_sel_d;
  logic [COLS-1:0]              col_out_q, col_out_d;
  logic                         frame_done_q, frame_done_d;

  logic [ROWS-1:0][COLS-1:0]    frame_rm;
  logic [ROWS-1:0]              row_onehot;
  logic [COLS-1:0]              row_pixels;
  logic                         wrap, last_row, boundary, lit;

  // Reorder the incoming bitmap into row-major storage; pure wiring.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      if (TRANSPOSE != 0) begin : g_colmajor
        assign frame_rm[r][c] = frame_in[c*ROWS + r];
      end else begin : g_rowmajor
        assign frame_rm[r][c] = frame_in[r*COLS + c];
      end
    end
  end

  assign wrap       = (presc_q == PW'(SCAN_DIV - 1));
  assign last_row   = (row_q == RW'(ROWS - 1));
  assign boundary   = enable && wrap && last_row;
  assign lit        = enable && (int'(presc_q) >= BLANK);
  assign row_onehot = ROWS'(1) << row_q;
  assign row_pixels = active_q[row_q];

  always_comb begin
    presc_d   = presc_q;
    row_d     = row_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;

    if (!enable) begin
      presc_d = '0;
      row_d   = '0;
    end else if (wrap) begin
      presc_d = '0;
      row_d   = last_row ? '0 : row_q + RW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // An accept needs pending=0, so it can never coincide with a swap.
    if (frame_valid && !pending_q) begin
      shadow_d  = frame_rm;
      pending_d = 1'b1;
    end else if (pending_q && (boundary || !enable)) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end

    row_sel_d    = enable ? ((ROW_ACTIVE_LOW != 0) ? ~row_onehot : row_onehot) : ROW_OFF;
    col_out_d    = lit ? ((COL_ACTIVE_LOW != 0) ? ~row_pixels : row_pixels) : COL_OFF;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      row_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      row_sel_q    <= ROW_OFF;
      col_out_q    <= COL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      row_q        <= row_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      row_sel_q    <= row_sel_d;
      col_out_q    <= col_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_ready = !pending_q;
  assign row_sel     = row_sel_q;
  assign col_out     = col_out_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Bench for led_matrix_scan_driver: table of frames with hand-derived row patterns, a frame
// scoreboard queue standing in for the shadow buffer, and a second instance with flipped pin polarity.
module tb_led_matrix_scan_driver;

  localparam int ROWS     = 7;
  localparam int COLS     = 5;
  localparam int SCAN_DIV = 4;
  localparam int BLANK    = 1;
  localparam int FRAME    = ROWS * SCAN_DIV;

  typedef logic [ROWS-1:0][COLS-1:0] rows_t;
  typedef struct packed {
    logic [ROWS*COLS-1:0] frame;
    rows_t                exp;   // col_out per row for the active-low-column instance
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 enable = 1'b0;
  logic                 frame_valid = 1'b0;
  logic [ROWS*COLS-1:0] frame_in = '0;
  logic                 frame_ready, frame_done, frame_ready2, frame_done2;
  logic [ROWS-1:0]      row_sel, row_sel2;
  logic [COLS-1:0]      col_out, col_out2;

  int    n_chk = 0;
  int    n_err = 0;
  int    pos   = 0;
  rows_t m_active = '1;
  rows_t drv_exp  = '1;
  rows_t pend_q[$];
  vec_t  vecs[8];

  led_matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK),
    .TRANSPOSE(1), .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_in(frame_in),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .row_sel(row_sel), .col_out(col_out), .frame_done(frame_done)
  );

  led_matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK),
    .TRANSPOSE(1), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0)
  ) dut_pol (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_in(frame_in),
    .frame_valid(frame_valid), .frame_ready(frame_ready2),
    .row_sel(row_sel2), .col_out(col_out2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_now();
    chk("rst_row_sel", row_sel, 7'h00);
    chk("rst_col_out", col_out, 5'h1F);
    chk("rst_ready",   frame_ready, 1'b1);
    chk("rst_done",    frame_done, 1'b0);
    chk("rst_row_sel_pol", row_sel2, 7'h7F);
    chk("rst_col_out_pol", col_out2, 5'h00);
  endtask

  // One clock: predict what the next edge produces, advance the model, then compare.
  task automatic step();
    logic [ROWS-1:0] e_rs, e_rs2;
    logic [COLS-1:0] e_col, e_col2;
    logic            e_done, e_rdy, bnd;
    if (!rst_n) begin
      e_rs = '0; e_col = '1; e_done = 1'b0;
      pos = 0; pend_q.delete(); m_active = '1;
    end else begin
      bnd = enable && (pos == FRAME - 1);
      if (enable) begin
        e_rs  = ROWS'(1) << (pos / SCAN_DIV);
        e_col = ((pos % SCAN_DIV) < BLANK) ? 5'h1F : m_active[pos / SCAN_DIV];
      end else begin
        e_rs  = '0;
        e_col = '1;
      end
      e_done = bnd;
      if (frame_valid && pend_q.size() == 0) pend_q.push_back(drv_exp);
      else if (pend_q.size() != 0 && (bnd || !enable)) m_active = pend_q.pop_front();
      pos = enable ? (pos + 1) % FRAME : 0;
    end
    e_rdy  = (pend_q.size() == 0);
    e_rs2  = ~e_rs;
    e_col2 = ~e_col;
    @(negedge clk);
    chk("row_sel", row_sel, e_rs);
    chk("col_out", col_out, e_col);
    chk("frame_done", frame_done, e_done);
    chk("frame_ready", frame_ready, e_rdy);
    chk("row_sel_pol", row_sel2, e_rs2);
    chk("col_out_pol", col_out2, e_col2);
    chk("ready_pol", frame_ready2, e_rdy);
    chk("done_pol", frame_done2, e_done);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input vec_t v);
    logic ok;
    ok = 1'b0;
    frame_in = v.frame; drv_exp = v.exp; frame_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = (pend_q.size() == 0);
      step();
    end
    frame_valid = 1'b0;
    frame_in    = {3'($urandom), $urandom};
    chk("accept_in_time", ok, 1'b1);
  endtask

  task automatic wait_pos(input int p, input logic need_empty);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      hit = (pos == p) && (!need_empty || pend_q.size() == 0);
      if (!hit) step();
    end
    chk("wait_pos", hit, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vecs[i].exp = '1;
    vecs[0].frame = 35'h4_0000_0000; vecs[0].exp[6] = 5'b01111;   // r6,c4
    vecs[1].frame = 35'h2_0000_0000; vecs[1].exp[5] = 5'b01111;   // r5,c4
    vecs[2].frame = 35'h0_0000_0001; vecs[2].exp[0] = 5'b11110;   // r0,c0
    vecs[3].frame = 35'h0_0000_0080; vecs[3].exp[0] = 5'b11101;   // r0,c1
    vecs[4].frame = 35'h0_0000_0140; vecs[4].exp[6] = 5'b11110;   // r6,c0 and r1,c1
    vecs[4].exp[1] = 5'b11101;
    vecs[5].frame = 35'h7_FFFF_FFFF; vecs[5].exp = '0;            // all lit
    vecs[6].frame = 35'h0_001F_C000;                              // column 2
    for (int r = 0; r < ROWS; r++) vecs[6].exp[r] = 5'b11011;
    vecs[7].frame = 35'h0_8102_0408; vecs[7].exp[3] = 5'b00000;   // row 3

    #1 rst_n = 1'b0;
    #2 chk_reset_now();
    run(2);
    rst_n  = 1'b1;
    enable = 1'b1;
    run(FRAME + 2);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i]);
      run(2 * FRAME);
    end

    // Frame B held valid while A is pending, then an accept landing on the boundary edge.
    wait_pos(3, 1'b1);
    send(vecs[6]);
    send(vecs[7]);
    run(2 * FRAME);
    wait_pos(FRAME - 1, 1'b1);
    send(vecs[1]);
    run(2 * FRAME + 4);

    // Enable dropped mid row 3 with a frame pending, then re-enabled.
    wait_pos(0, 1'b1);
    send(vecs[3]);
    wait_pos(3 * SCAN_DIV + 2, 1'b0);
    enable = 1'b0;
    run(4);
    enable = 1'b1;
    run(FRAME + 6);

    // Asynchronous reset with frame_done high and another frame on the handshake.
    wait_pos(0, 1'b1);
    send(vecs[4]);
    frame_in = vecs[5].frame; drv_exp = vecs[5].exp; frame_valid = 1'b1;
    wait_pos(0, 1'b0);
    chk("done_before_reset", frame_done, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_reset_now();
    frame_valid = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(FRAME + 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
